// File: rtl/keypad_debouncer_if.sv
// Raw keypad lines in, clean one-cycle key events out.
`timescale 1ns/1ps

interface keypad_debouncer_if;
    logic [9:0] raw_digits;
    logic       raw_confirm;
    logic       raw_shuffle;
    logic [9:0] digit_buttons;
    logic       confirm_button;
    logic       shuffle_button;
    logic       multi_press;
    logic       busy;

    // Debouncer side: consumes raw keys, produces events
    modport slave (
        input  raw_digits, raw_confirm, raw_shuffle,
        output digit_buttons, confirm_button, shuffle_button, multi_press, busy
    );

    // Keypad/consumer side
    modport master (
        output raw_digits, raw_confirm, raw_shuffle,
        input  digit_buttons, confirm_button, shuffle_button, multi_press, busy
    );
endinterface

// File: rtl/keypad_debouncer.sv
// Synchronises and debounces 10 digit keys plus confirm/shuffle, emitting one
// single-cycle one-hot pulse per accepted press and rejecting multi-key presses.
`timescale 1ns/1ps

module keypad_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 20,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                 clk,
    input  logic                 rstn,
    keypad_debouncer_if.slave    kp
);

    localparam int unsigned KEY_W = 12;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS_QUAL   = 3'd1,
        EMIT         = 3'd2,
        HELD         = 3'd3,
        RELEASE_QUAL = 3'd4
    } state_t;

    logic [KEY_W-1:0] sync1;
    logic [KEY_W-1:0] s;
    logic [KEY_W-1:0] key;
    logic [KEY_W-1:0] key_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    state_t           state;
    state_t           state_n;

    logic [KEY_W-1:0] pulse_n;
    logic             multi_n;
    logic             busy_n;
    logic             s_zero;
    logic             s_onehot;

    assign s_zero   = (s == '0);
    assign s_onehot = $onehot(s);

    // Two-flop synchroniser on the asynchronous key lines
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= {kp.raw_shuffle, kp.raw_confirm, kp.raw_digits};
            s     <= sync1;
        end
    end

    // State register, qualification counter, latched key and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state             <= IDLE;
            cnt               <= '0;
            key               <= '0;
            kp.digit_buttons  <= '0;
            kp.confirm_button <= 1'b0;
            kp.shuffle_button <= 1'b0;
            kp.multi_press    <= 1'b0;
            kp.busy           <= 1'b0;
        end else begin
            state             <= state_n;
            cnt               <= cnt_n;
            key               <= key_n;
            kp.digit_buttons  <= pulse_n[9:0];
            kp.confirm_button <= pulse_n[10];
            kp.shuffle_button <= pulse_n[11];
            kp.multi_press    <= multi_n;
            kp.busy           <= busy_n;
        end
    end

    // Next-state logic; the counter restarts from zero on every state entry
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        key_n   = key;
        case (state)
            IDLE: begin
                if (!s_zero) begin
                    cnt_n = '0;
                    if (s_onehot) begin
                        key_n   = s;
                        state_n = PRESS_QUAL;
                    end else begin
                        state_n = HELD;
                    end
                end
            end
            PRESS_QUAL: begin
                if (s == key) begin
                    if (cnt == CNT_LAST) begin
                        cnt_n   = '0;
                        state_n = EMIT;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end else begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end
            EMIT: begin
                cnt_n   = '0;
                state_n = HELD;
            end
            HELD: begin
                if (s_zero) begin
                    cnt_n   = '0;
                    state_n = RELEASE_QUAL;
                end
            end
            RELEASE_QUAL: begin
                if (s_zero) begin
                    if (cnt == CNT_LAST) begin
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end else begin
                    cnt_n   = '0;
                    state_n = HELD;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // Output decode: values are loaded into the output flops on the same edge
    // that enters EMIT / HELD, so the pulse is visible while the FSM is in EMIT
    always_comb begin
        pulse_n = '0;
        multi_n = 1'b0;
        busy_n  = (state_n != IDLE);
        if (state == PRESS_QUAL && state_n == EMIT) begin
            pulse_n = key;
        end
        if (state == IDLE && !s_zero && !s_onehot) begin
            multi_n = 1'b1;
        end
    end

endmodule

// File: tb/tb_keypad_debouncer.sv
// Randomised scoreboard bench for keypad_debouncer with a run-length reference model.
`timescale 1ns/1ps

module tb_keypad_debouncer;

    localparam int unsigned DEB = 4;

    typedef struct {
        logic [12:0] val;     // {multi, shuffle, confirm, digits}
        int unsigned edge_i;
    } exp_t;

    typedef enum int {M_IDLE, M_CAND, M_LOCK} mode_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    keypad_debouncer_if kp();

    keypad_debouncer #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk  (clk),
        .rstn (rstn),
        .kp   (kp)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int unsigned edge_n   = 0;
    bit          done     = 1'b0;
    exp_t        sb[$];
    bit          model_busy = 1'b0;

    // Directed latency expectations handed to the monitor
    int          dir_seq      = 0;
    int          dir_done_seq = 0;
    int unsigned dir_edge     = 0;
    logic [9:0]  dir_val      = '0;

    // Reference model: keys pass a 2-sample delay, a press is accepted when a
    // single key seen from idle stays identical for DEB more samples, and the
    // pad re-arms only after DEB+1 consecutive all-released samples.
    initial begin
        logic [11:0] p1, p2, s, cand;
        mode_t       mode;
        int          need, zrun;
        bit          skip;
        exp_t        e;
        p1 = '0; p2 = '0; cand = '0; mode = M_IDLE; need = 0; zrun = 0; skip = 1'b0;
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                p1 = '0; p2 = '0; mode = M_IDLE; skip = 1'b0; zrun = 0;
                model_busy = 1'b0;
                sb.delete();
            end else begin
                edge_n++;
                s  = p2;
                p2 = p1;
                p1 = {kp.raw_shuffle, kp.raw_confirm, kp.raw_digits};
                case (mode)
                    M_IDLE: begin
                        if (s != 0) begin
                            if ($countones(s) == 1) begin
                                cand = s;
                                need = DEB;
                                mode = M_CAND;
                            end else begin
                                e.val = {1'b1, 12'h000};
                                e.edge_i = edge_n;
                                sb.push_back(e);
                                mode = M_LOCK;
                                zrun = 0;
                                skip = 1'b0;
                            end
                        end
                    end
                    M_CAND: begin
                        if (s == cand) begin
                            need--;
                            if (need == 0) begin
                                e.val = {1'b0, cand};
                                e.edge_i = edge_n;
                                sb.push_back(e);
                                mode = M_LOCK;
                                zrun = 0;
                                skip = 1'b1;
                            end
                        end else begin
                            mode = M_IDLE;
                        end
                    end
                    default: begin
                        if (skip) begin
                            skip = 1'b0;
                        end else if (s == 0) begin
                            zrun++;
                            if (zrun == DEB + 1) mode = M_IDLE;
                        end else begin
                            zrun = 0;
                        end
                    end
                endcase
                model_busy = (mode != M_IDLE);
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an event
    initial begin
        logic [12:0] outv;
        exp_t        e;
        forever begin
            @(negedge clk);
            outv = {kp.multi_press, kp.shuffle_button, kp.confirm_button, kp.digit_buttons};
            if (done) begin
                checks++;
                if (sb.size() != 0) begin
                    failures++;
                    $display("FAIL sb_drain: %0d expected events never seen", sb.size());
                end
                checks++;
                if (dir_seq != dir_done_seq) begin
                    failures++;
                    $display("FAIL directed_pending: seq %0d done %0d", dir_seq, dir_done_seq);
                end
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
            if (!rstn) begin
                checks++;
                if (outv != 0 || kp.busy !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_outputs: out=%h busy=%b required 0", outv, kp.busy);
                end
            end else begin
                checks++;
                if (kp.busy !== model_busy) begin
                    failures++;
                    $display("FAIL busy: edge %0d got %b expected %b", edge_n, kp.busy, model_busy);
                end
                while (sb.size() > 0 && sb[0].edge_i < edge_n) begin
                    e = sb.pop_front();
                    checks++;
                    failures++;
                    $display("FAIL missing_event: expected %h at edge %0d", e.val, e.edge_i);
                end
                if (outv != 0) begin
                    checks++;
                    if ($countones(outv) != 1) begin
                        failures++;
                        $display("FAIL one_hot: edge %0d out=%h", edge_n, outv);
                    end
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_event: edge %0d out=%h expected none", edge_n, outv);
                    end else begin
                        e = sb.pop_front();
                        if (e.val !== outv || e.edge_i != edge_n) begin
                            failures++;
                            $display("FAIL event: got %h at edge %0d expected %h at edge %0d",
                                     outv, edge_n, e.val, e.edge_i);
                        end
                    end
                    if (dir_seq != dir_done_seq) begin
                        checks++;
                        if (outv[9:0] !== dir_val || outv[12:10] != 0 || edge_n != dir_edge) begin
                            failures++;
                            $display("FAIL latency: got %h at edge %0d required digits %h at edge %0d",
                                     outv, edge_n, dir_val, dir_edge);
                        end
                        dir_done_seq = dir_seq;
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: stimulus did not complete");
        $fatal(1, "timeout");
    end

    task automatic set_keys(input logic [11:0] v);
        {kp.raw_shuffle, kp.raw_confirm, kp.raw_digits} = v;
    endtask

    // Present v for n sampling edges
    task automatic hold(input logic [11:0] v, input int n);
        @(posedge clk);
        #2;
        set_keys(v);
        repeat (n - 1) @(posedge clk);
    endtask

    // Stable press of a digit whose first sample is edge 0: pulse at edge DEB+3
    task automatic timed_press(input logic [11:0] v, input int n);
        @(posedge clk);
        #2;
        set_keys(v);
        dir_edge = edge_n + DEB + 3;
        dir_val  = v[9:0];
        dir_seq++;
        repeat (n - 1) @(posedge clk);
    endtask

    initial begin
        logic [11:0] one, v, v2;
        int          kind;
        one = 12'd1;
        set_keys('0);
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;
        hold('0, 3);

        // Clean press
        timed_press(12'h008, 12);
        hold('0, 12);
        // Press bounce then stable
        hold(12'h008, 2);
        hold('0, 1);
        timed_press(12'h008, 12);
        hold('0, 12);
        // Simultaneous keys, short release, then full release
        hold(12'h082, 8);
        hold('0, 2);
        hold(12'h002, 4);
        hold('0, 10);
        // Roll-over
        hold(12'h020, 12);
        hold(12'h024, 8);
        hold(12'h020, 3);
        hold('0, 10);
        // Release bounce on confirm
        hold(12'h400, 10);
        hold('0, 2);
        hold(12'h400, 5);
        hold('0, 10);
        // Reset while qualifying shuffle
        hold(12'h800, 4);
        #2 rstn = 1'b0;
        set_keys('0);
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        hold('0, 10);

        // Random patterns
        for (int it = 0; it < 150; it++) begin
            kind = int'($urandom_range(0, 4));
            v  = one << $urandom_range(0, 11);
            v2 = one << $urandom_range(0, 11);
            case (kind)
                0: begin
                    hold(v, int'($urandom_range(1, 10)));
                    hold('0, int'($urandom_range(1, 8)));
                end
                1: begin
                    repeat ($urandom_range(1, 4)) begin
                        hold(v, int'($urandom_range(1, 3)));
                        hold('0, int'($urandom_range(1, 2)));
                    end
                    hold(v, int'($urandom_range(4, 10)));
                    hold('0, int'($urandom_range(1, 8)));
                end
                2: begin
                    hold(12'($urandom_range(1, 4095)), int'($urandom_range(1, 8)));
                    hold('0, int'($urandom_range(1, 8)));
                end
                3: begin
                    hold(v, 8);
                    hold(v | v2, int'($urandom_range(1, 6)));
                    hold('0, int'($urandom_range(1, 8)));
                end
                default: begin
                    hold(v, 8);
                    repeat ($urandom_range(1, 3)) begin
                        hold('0, int'($urandom_range(1, 3)));
                        hold(v, int'($urandom_range(1, 2)));
                    end
                    hold('0, 8);
                end
            endcase
        end
        hold('0, 10);
        done = 1'b1;
    end

endmodule
